// File: rtl/pipe_addsub_if.sv
// -----------------------------------------------------------------------------
// pipe_addsub_if
//
// Bundles the operand/result handshake of pipe_addsub.
//
//   master modport : the side that supplies operands and consumes results
//                    (operand-fetch stage / result mux, or a testbench)
//   slave modport  : the arithmetic pipeline itself
//
// Signals
//   in_valid  operand beat present             (master -> slave)
//   in_ready  pipeline accepts a beat          (slave  -> master)
//   a, b      operands, WIDTH bits             (master -> slave)
//   sub       1: a - b, 0: a + b               (master -> slave)
//   is_signed 1: two's-complement overflow     (master -> slave)
//   out_valid result present                   (slave  -> master)
//   out_ready consumer takes the result        (master -> slave)
//   s         result, WIDTH bits               (slave  -> master)
//   carry     raw carry-out of the MSB         (slave  -> master)
//   overflow  overflow for the selected mode   (slave  -> master)
// -----------------------------------------------------------------------------
interface pipe_addsub_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        output sub,
        output is_signed,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  s,
        input  carry,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sub,
        input  is_signed,
        input  out_ready,
        output in_ready,
        output out_valid,
        output s,
        output carry,
        output overflow
    );

endinterface

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
//
// Pipelined integer adder/subtractor. The WIDTH-bit carry chain is cut into
// STAGES equal segments; each pipeline stage adds one segment using the carry
// registered by the stage before it, so the pipeline depth equals STAGES.
// Subtraction is a + ~b + 1. Overflow follows either the two's-complement rule
// or the unsigned carry/borrow rule, chosen per beat by is_signed.
//
// Parameters
//   WIDTH  : operand/result width, >= 2
//   STAGES : number of carry-chain segments = pipeline depth; must divide WIDTH
//
// Ports
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset; clears every stage valid and the
//         s/carry/overflow output registers
//   bus : pipe_addsub_if.slave (in_valid/in_ready/a/b/sub/is_signed in,
//         out_valid/out_ready/s/carry/overflow out)
//
// Flow control
//   The whole pipeline advances as one unit: adv = !out_valid || out_ready.
//   Bubbles are kept (fixed latency), results leave in acceptance order, and
//   in_ready is simply adv. All result outputs come straight from flops.
//
// Build option
//   PIPE_ADDSUB_SAT_EN : when defined, an overflowing result is clamped in the
//                        last stage (signed: toward the sign of a; unsigned
//                        add: all ones; unsigned sub: zero). carry and
//                        overflow still report the raw condition. When not
//                        defined the result wraps modulo 2^WIDTH and no clamp
//                        logic exists.
// -----------------------------------------------------------------------------
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    pipe_addsub_if.slave   bus
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Refuse to elaborate with an unusable geometry.
    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_addsub: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // -------------------------------------------------------------------------
    // Per-stage state. Index i is the register at the output of stage i.
    //   x_r : low segments already summed, upper segments still operand A.
    //         In the last stage this is the finished (possibly clamped) sum.
    //   y_r : operand B' = b ^ {WIDTH{sub}} (only upper segments still needed)
    //   c_r : carry out of the segment summed in this stage
    // -------------------------------------------------------------------------
    logic             v_r   [STAGES];
    logic             c_r   [STAGES];
    logic             sub_r [STAGES];
    logic             sgn_r [STAGES];
    logic [WIDTH-1:0] x_r   [STAGES];
    logic [WIDTH-1:0] y_r   [STAGES];
    logic             ovf_r;

    // Inputs seen by each stage: the port for stage 0, the previous register
    // for every later stage.
    logic             src_v_s   [STAGES];
    logic             src_c_s   [STAGES];
    logic             src_sub_s [STAGES];
    logic             src_sgn_s [STAGES];
    logic [WIDTH-1:0] src_x_s   [STAGES];
    logic [WIDTH-1:0] src_y_s   [STAGES];

    logic [SEG:0]     seg_sum_s [STAGES];
    logic [WIDTH-1:0] nxt_x_s   [STAGES];
    logic             nxt_c_s   [STAGES];

    logic             adv_s;
    logic             a_msb_s;
    logic             b_msb_s;
    logic             sum_msb_s;
    logic             ovf_s;
    logic [WIDTH-1:0] res_s;

    // Global advance: every stage moves when the output slot is free or drains.
    always_comb begin
        adv_s = ~v_r[LAST] | bus.out_ready;
    end

    // Stage inputs and the segment adder of every stage.
    always_comb begin
        src_v_s[0]   = bus.in_valid;
        src_c_s[0]   = bus.sub;
        src_sub_s[0] = bus.sub;
        src_sgn_s[0] = bus.is_signed;
        src_x_s[0]   = bus.a;
        src_y_s[0]   = bus.b ^ {WIDTH{bus.sub}};
        for (int i = 1; i < STAGES; i++) begin
            src_v_s[i]   = v_r[i-1];
            src_c_s[i]   = c_r[i-1];
            src_sub_s[i] = sub_r[i-1];
            src_sgn_s[i] = sgn_r[i-1];
            src_x_s[i]   = x_r[i-1];
            src_y_s[i]   = y_r[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            // One SEG-bit slice plus incoming carry; MSB of the sum is carry-out.
            seg_sum_s[i] = {1'b0, src_x_s[i][i*SEG +: SEG]}
                         + {1'b0, src_y_s[i][i*SEG +: SEG]}
                         + {{SEG{1'b0}}, src_c_s[i]};
            nxt_x_s[i]                = src_x_s[i];
            nxt_x_s[i][i*SEG +: SEG]  = seg_sum_s[i][SEG-1:0];
            nxt_c_s[i]                = seg_sum_s[i][SEG];
        end
    end

    // Last-stage overflow decision and optional clamp.
    always_comb begin
        // The top segment of x is still untouched operand A on entry to the
        // last stage, so its MSB is a[MSB].
        a_msb_s   = src_x_s[LAST][WIDTH-1];
        b_msb_s   = src_y_s[LAST][WIDTH-1];
        sum_msb_s = nxt_x_s[LAST][WIDTH-1];

        if (src_sgn_s[LAST]) begin
            // Same-sign operands producing a result of the other sign.
            ovf_s = (a_msb_s == b_msb_s) && (sum_msb_s != a_msb_s);
        end else if (src_sub_s[LAST]) begin
            // Unsigned subtract: carry-out 0 means a borrow occurred.
            ovf_s = ~nxt_c_s[LAST];
        end else begin
            ovf_s = nxt_c_s[LAST];
        end

        res_s = nxt_x_s[LAST];
`ifdef PIPE_ADDSUB_SAT_EN
        if (ovf_s) begin
            case ({src_sgn_s[LAST], src_sub_s[LAST]})
                2'b10, 2'b11: begin
                    // Signed overflow always goes past the limit on a's side.
                    if (a_msb_s) begin
                        res_s = {1'b1, {(WIDTH-1){1'b0}}};
                    end else begin
                        res_s = {1'b0, {(WIDTH-1){1'b1}}};
                    end
                end
                2'b01:   res_s = {WIDTH{1'b0}};
                2'b00:   res_s = {WIDTH{1'b1}};
                default: res_s = nxt_x_s[LAST];
            endcase
        end else begin
            res_s = nxt_x_s[LAST];
        end
`endif
    end

    // Pipeline registers: cleared by reset, shifted together on adv, else held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                v_r[i]   <= 1'b0;
                c_r[i]   <= 1'b0;
                sub_r[i] <= 1'b0;
                sgn_r[i] <= 1'b0;
                x_r[i]   <= {WIDTH{1'b0}};
                y_r[i]   <= {WIDTH{1'b0}};
            end
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            for (int i = 0; i < STAGES; i++) begin
                v_r[i]   <= src_v_s[i];
                c_r[i]   <= nxt_c_s[i];
                sub_r[i] <= src_sub_s[i];
                sgn_r[i] <= src_sgn_s[i];
                y_r[i]   <= src_y_s[i];
                if (i == LAST) begin
                    x_r[i] <= res_s;
                end else begin
                    x_r[i] <= nxt_x_s[i];
                end
            end
            ovf_r <= ovf_s;
        end else begin
            // Stall: every stage keeps its beat, outputs stay stable.
            ovf_r <= ovf_r;
        end
    end

    assign bus.in_ready  = adv_s;
    assign bus.out_valid = v_r[LAST];
    assign bus.s         = x_r[LAST];
    assign bus.carry     = c_r[LAST];
    assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipe_addsub
//
// Directed bench for pipe_addsub at WIDTH=32. The main instance uses
// STAGES=2; STAGES=1 and STAGES=4 instances are exercised in the carry-ripple
// latency sweep. Expected values are hand-computed constants, plus a 64-bit
// arithmetic reference for the randomized back-pressure stream.
// -----------------------------------------------------------------------------
module tb_pipe_addsub;

`ifdef PIPE_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    pipe_addsub_if #(.WIDTH(32)) if1 ();
    pipe_addsub_if #(.WIDTH(32)) if2 ();
    pipe_addsub_if #(.WIDTH(32)) if4 ();

    pipe_addsub #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    pipe_addsub #(.WIDTH(32), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    pipe_addsub #(.WIDTH(32), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Independent reference: 64-bit arithmetic on the zero/sign-extended operands.
    task automatic ref_model(input logic [31:0] ma, input logic [31:0] mb,
                             input logic msub, input logic msgn,
                             output logic [31:0] ms, output logic mc, output logic mo);
        longint ua, ub, ur, sa, sb, sr;
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            ur = ua - ub;
            mc = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub;
            mc = (ur >= 64'sd4294967296);
            sr = sa + sb;
        end
        ms = ur[31:0];
        if (msgn) mo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        else      mo = msub ? !mc : mc;
        if (SAT && mo) begin
            if (msgn) ms = (sr > 64'sd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            else      ms = msub ? 32'h0000_0000 : 32'hFFFF_FFFF;
        end
    endtask

    // One beat into the STAGES=2 instance; returns its result and edge count.
    task automatic beat2(input logic [31:0] ta, input logic [31:0] tb,
                         input logic tsub, input logic tsgn,
                         output logic [31:0] rs, output logic rc, output logic ro,
                         output int lat);
        @(posedge clk); #1;
        if2.a = ta; if2.b = tb; if2.sub = tsub; if2.is_signed = tsgn;
        if2.in_valid = 1'b1; if2.out_ready = 1'b1;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        lat = 1;
        while (!if2.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = if2.s; rc = if2.carry; ro = if2.overflow;
    endtask

    task automatic set_all(input logic v, input logic [31:0] ta, input logic [31:0] tb);
        if1.in_valid = v; if1.a = ta; if1.b = tb; if1.sub = 1'b0; if1.is_signed = 1'b0;
        if2.in_valid = v; if2.a = ta; if2.b = tb; if2.sub = 1'b0; if2.is_signed = 1'b0;
        if4.in_valid = v; if4.a = ta; if4.b = tb; if4.sub = 1'b0; if4.is_signed = 1'b0;
        if1.out_ready = 1'b1; if2.out_ready = 1'b1; if4.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b0;
        set_all(1'b0, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        vectors++; if (if2.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", if2.out_valid); end
        vectors++; if (if2.s !== 32'h0) begin miscompares++; $display("FAIL rst_s: got %h want 00000000", if2.s); end
        vectors++; if ({if2.carry, if2.overflow} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b want 00", {if2.carry, if2.overflow}); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++; if (if2.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", if2.in_ready); end

        // Two beats in flight, output stalled, then reset mid-cycle.
        @(posedge clk); #1;
        if2.a = 32'h7FFF_FFFF; if2.b = 32'h1; if2.sub = 1'b0; if2.is_signed = 1'b1;
        if2.in_valid = 1'b1; if2.out_ready = 1'b0;
        @(posedge clk); #1;
        if2.a = 32'h1234_5678; if2.b = 32'h1111_1111;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        vectors++; if (if2.out_valid !== 1'b1) begin miscompares++; $display("FAIL inflight_valid: got %b want 1", if2.out_valid); end
        vectors++; if (if2.in_ready !== 1'b0) begin miscompares++; $display("FAIL inflight_ready: got %b want 0", if2.in_ready); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (if2.out_valid !== 1'b0 || if2.s !== 32'h0 || if2.overflow !== 1'b0) begin
            miscompares++; $display("FAIL midrst_clear: got v=%b s=%h ov=%b want v=0 s=00000000 ov=0", if2.out_valid, if2.s, if2.overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        if2.out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (if2.out_valid) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_flush: got stale output=%b want 0", seen); end
        vectors++; if (if2.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", if2.in_ready); end
    endtask

    task automatic test_signed_add();
        logic [31:0] rs; logic rc, ro; int lat;
        beat2(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, rs, rc, ro, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sadd_latency: got %0d want 2", lat); end
        vectors++; if (rs !== (SAT ? 32'h7FFF_FFFF : 32'h8000_0000)) begin miscompares++; $display("FAIL sadd_s: got %h want %h", rs, SAT ? 32'h7FFF_FFFF : 32'h8000_0000); end
        vectors++; if (ro !== 1'b1) begin miscompares++; $display("FAIL sadd_ovf: got %b want 1", ro); end
        vectors++; if (rc !== 1'b0) begin miscompares++; $display("FAIL sadd_carry: got %b want 0", rc); end
    endtask

    task automatic test_signed_sub();
        logic [31:0] rs; logic rc, ro; int lat;
        beat2(32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 1'b1, rs, rc, ro, lat);
        vectors++; if (rs !== 32'h0000_0008) begin miscompares++; $display("FAIL ssub_mixed_s: got %h want 00000008", rs); end
        vectors++; if ({rc, ro} !== 2'b00) begin miscompares++; $display("FAIL ssub_mixed_flags: got c/ov=%b want 00", {rc, ro}); end
        beat2(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, rs, rc, ro, lat);
        vectors++; if (rs !== (SAT ? 32'h8000_0000 : 32'h7FFF_FFFF)) begin miscompares++; $display("FAIL ssub_ovf_s: got %h want %h", rs, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF); end
        vectors++; if ({rc, ro} !== 2'b11) begin miscompares++; $display("FAIL ssub_ovf_flags: got c/ov=%b want 11", {rc, ro}); end
    endtask

    task automatic test_unsigned();
        logic [31:0] rs; logic rc, ro; int lat;
        beat2(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, lat);
        vectors++; if (rs !== (SAT ? 32'hFFFF_FFFF : 32'h0000_0000)) begin miscompares++; $display("FAIL uadd_s: got %h want %h", rs, SAT ? 32'hFFFF_FFFF : 32'h0000_0000); end
        vectors++; if ({rc, ro} !== 2'b11) begin miscompares++; $display("FAIL uadd_flags: got c/ov=%b want 11", {rc, ro}); end
        beat2(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, rs, rc, ro, lat);
        vectors++; if (rs !== (SAT ? 32'h0000_0000 : 32'hFFFF_FFFE)) begin miscompares++; $display("FAIL usub_s: got %h want %h", rs, SAT ? 32'h0000_0000 : 32'hFFFF_FFFE); end
        vectors++; if ({rc, ro} !== 2'b01) begin miscompares++; $display("FAIL usub_flags: got c/ov=%b want 01", {rc, ro}); end
    endtask

    task automatic test_backpressure();
        logic [31:0] as [8];
        logic [31:0] bs [8];
        logic        subs [8];
        logic        sgns [8];
        logic [31:0] es [$];
        logic        ec [$];
        logic        eo [$];
        logic [31:0] ms, held_s, snap_s;
        logic        mc, mo, held_c, held_o, snap_c, snap_o;
        bit          held, acc, cons;
        int          sent, got, cyc;
        for (int i = 0; i < 8; i++) begin
            as[i] = $urandom; bs[i] = $urandom;
            subs[i] = 1'($urandom_range(0, 1)); sgns[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; cyc = 0; held = 1'b0;
        @(posedge clk); #1;
        while (got < 8 && cyc < 300) begin
            if2.out_ready = 1'($urandom_range(0, 1));
            if2.in_valid  = (sent < 8);
            if (sent < 8) begin
                if2.a = as[sent]; if2.b = bs[sent]; if2.sub = subs[sent]; if2.is_signed = sgns[sent];
            end
            #1;
            if (held) begin
                vectors++;
                if (if2.out_valid !== 1'b1 || if2.s !== held_s || if2.carry !== held_c || if2.overflow !== held_o) begin
                    miscompares++; $display("FAIL stall_hold: got v=%b s=%h want v=1 s=%h", if2.out_valid, if2.s, held_s);
                end
            end
            if (if2.out_valid && !if2.out_ready) begin
                vectors++; if (if2.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b want 0", if2.in_ready); end
                held = 1'b1; held_s = if2.s; held_c = if2.carry; held_o = if2.overflow;
            end else begin
                held = 1'b0;
            end
            acc  = if2.in_valid && if2.in_ready;
            cons = if2.out_valid && if2.out_ready;
            snap_s = if2.s; snap_c = if2.carry; snap_o = if2.overflow;
            @(posedge clk); #1;
            if (cons) begin
                vectors++;
                if (es.size() == 0) begin
                    miscompares++; $display("FAIL bp_extra: got unexpected result %h want none", snap_s);
                end else begin
                    ms = es.pop_front(); mc = ec.pop_front(); mo = eo.pop_front();
                    if (snap_s !== ms || snap_c !== mc || snap_o !== mo) begin
                        miscompares++; $display("FAIL bp_result%0d: got s=%h c=%b ov=%b want s=%h c=%b ov=%b", got, snap_s, snap_c, snap_o, ms, mc, mo);
                    end
                end
                got++;
            end
            if (acc) begin
                ref_model(as[sent], bs[sent], subs[sent], sgns[sent], ms, mc, mo);
                es.push_back(ms); ec.push_back(mc); eo.push_back(mo);
                sent++;
            end
            cyc++;
        end
        vectors++; if (got !== 8) begin miscompares++; $display("FAIL bp_count: got %0d results want 8", got); end
        if2.in_valid = 1'b0; if2.out_ready = 1'b1;
        held = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (if2.out_valid) held = 1'b1;
        end
        vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL bp_dup: got extra output=%b want 0", held); end
    endtask

    task automatic test_segmentation();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] te [3];
        int          st [3];
        logic        ov [3];
        logic [31:0] os [3];
        bit          ev;
        ta[0] = 32'h0000_FFFF; tb[0] = 32'h0000_0001; te[0] = 32'h0001_0000;
        ta[1] = 32'h0000_FFFF; tb[1] = 32'h0000_0002; te[1] = 32'h0001_0001;
        ta[2] = 32'hFFFF_FFFF; tb[2] = 32'h0000_0001; te[2] = 32'h0000_0000;
        st[0] = 1; st[1] = 2; st[2] = 4;
        @(posedge clk); #1;
        set_all(1'b1, ta[0], tb[0]);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            ov[0] = if1.out_valid; os[0] = if1.s;
            ov[1] = if2.out_valid; os[1] = if2.s;
            ov[2] = if4.out_valid; os[2] = if4.s;
            for (int k = 0; k < 3; k++) begin
                ev = (e >= st[k]) && (e < st[k] + 3);
                vectors++;
                if (ov[k] !== ev) begin
                    miscompares++; $display("FAIL sweep_valid st%0d edge%0d: got %b want %b", st[k], e, ov[k], ev);
                end
                if (ev) begin
                    vectors++;
                    if (os[k] !== te[e - st[k]]) begin
                        miscompares++; $display("FAIL sweep_s st%0d edge%0d: got %h want %h", st[k], e, os[k], te[e - st[k]]);
                    end
                end
            end
            if (e < 3) set_all(1'b1, ta[e], tb[e]);
            else       set_all(1'b0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_signed_add();
        test_signed_sub();
        test_unsigned();
        test_backpressure();
        test_segmentation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
